// File: rtl/rram_synapse_row.sv
// Row of N_CELL RRAM synapse conductances sharing one word line.
// Supports SET pulse programming, serial forward MAC and a serial backward pass with in-place update.
module rram_synapse_row #(
  parameter int N_CELL   = 4,
  parameter int W_W      = 8,
  parameter int X_W      = 8,
  parameter int D_W      = 8,
  parameter int LR_SHIFT = 3,
  parameter int SET_STEP = 1,
  localparam int SEL_W   = (N_CELL > 1) ? $clog2(N_CELL) : 1,
  localparam int ACC_W   = W_W + X_W + SEL_W,
  localparam int DO_W    = D_W + 1 + W_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wl,
  input  logic [1:0]              cmd,
  input  logic [7:0]              cmd_arg,
  input  logic [SEL_W-1:0]        cmd_sel,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [N_CELL*X_W-1:0]   x_in,
  input  logic [D_W-1:0]          d_in1,
  input  logic [D_W-1:0]          d_in2,
  output logic [ACC_W-1:0]        acc_out,
  output logic                    acc_valid,
  output logic [DO_W-1:0]         dlt_out,
  output logic [SEL_W-1:0]        dlt_idx,
  output logic                    dlt_valid,
  output logic                    done,
  output logic [W_W-1:0]          g_out
);

  localparam logic [1:0] CMD_CLR = 2'd0;
  localparam logic [1:0] CMD_SET = 2'd1;
  localparam logic [1:0] CMD_FWD = 2'd2;
  localparam logic [1:0] CMD_BCK = 2'd3;

  localparam logic [SEL_W:0]   NC_V = (SEL_W+1)'(N_CELL);
  localparam logic [SEL_W-1:0] LAST = SEL_W'(N_CELL - 1);
  localparam int P_W = D_W + 1 + W_W + X_W + 2;
  localparam int U_W = D_W + 1 + X_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_SET, S_FWD, S_BACK} state_t;

  state_t                          state_q, state_d;
  logic [N_CELL-1:0][W_W-1:0]      g_q, g_d;
  logic [N_CELL-1:0][X_W-1:0]      x_q, x_d;
  logic [D_W-1:0]                  d1_q, d1_d, d2_q, d2_d;
  logic [SEL_W-1:0]                sel_q, sel_d, idx_q, idx_d;
  logic [7:0]                      cnt_q, cnt_d;
  logic [ACC_W-1:0]                acc_q, acc_d, acc_out_q, acc_out_d;
  logic [DO_W-1:0]                 dlt_out_q, dlt_out_d;
  logic [SEL_W-1:0]                dlt_idx_q, dlt_idx_d;
  logic                            acc_valid_q, acc_valid_d;
  logic                            dlt_valid_q, dlt_valid_d;
  logic                            done_q, done_d;

  logic                            accept, last, sel_ok;
  logic [W_W-1:0]                  g_cur, g_sel, set_val, g_new;
  logic [X_W-1:0]                  x_cur, xq;
  logic [W_W:0]                    set_sum;
  logic [W_W+X_W-1:0]              prod_fwd;
  logic [ACC_W-1:0]                acc_sum;
  logic signed [D_W:0]             dsum;
  logic [X_W:0]                    x_comp;
  logic [2*X_W:0]                  x_sq;
  logic signed [P_W-1:0]           dsum_p, g_p, xq_p, p_dlt;
  logic signed [U_W-1:0]           dsum_u, x_u, p_upd, upd;
  logic signed [U_W+1:0]           g_diff;
  logic [DO_W-1:0]                 dlt_val;

  assign cmd_ready = (state_q == S_IDLE) && wl && !rst;
  assign accept    = cmd_valid && cmd_ready;
  assign last      = (idx_q == LAST);
  assign sel_ok    = ({1'b0, sel_q} < NC_V);

  assign g_out     = ({1'b0, cmd_sel} < NC_V) ? g_q[cmd_sel] : '0;
  assign acc_out   = acc_out_q;
  assign acc_valid = acc_valid_q;
  assign dlt_out   = dlt_out_q;
  assign dlt_idx   = dlt_idx_q;
  assign dlt_valid = dlt_valid_q;
  assign done      = done_q;

  // Per-cell datapath shared by FWD and BACK; idx_q walks the row.
  always_comb begin
    g_cur    = g_q[idx_q];
    x_cur    = x_q[idx_q];
    g_sel    = sel_ok ? g_q[sel_q] : '0;
    set_sum  = {1'b0, g_sel} + (W_W+1)'(SET_STEP);
    set_val  = set_sum[W_W] ? '1 : set_sum[W_W-1:0];

    prod_fwd = {{X_W{1'b0}}, g_cur} * {{W_W{1'b0}}, x_cur};
    acc_sum  = acc_q + {{SEL_W{1'b0}}, prod_fwd};

    dsum     = {d1_q[D_W-1], d1_q} + {d2_q[D_W-1], d2_q};
    x_comp   = {1'b1, {X_W{1'b0}}} - {1'b0, x_cur};
    x_sq     = {{(X_W+1){1'b0}}, x_cur} * {{X_W{1'b0}}, x_comp};
    xq       = X_W'(x_sq >> X_W);

    dsum_p   = {{(P_W-D_W-1){dsum[D_W]}}, dsum};
    g_p      = {{(P_W-W_W){1'b0}}, g_cur};
    xq_p     = {{(P_W-X_W){1'b0}}, xq};
    p_dlt    = dsum_p * g_p * xq_p;
    dlt_val  = DO_W'(p_dlt >>> X_W);

    // Floor-shifted learning-rate step, then clamp to the conductance range.
    dsum_u   = {{(U_W-D_W-1){dsum[D_W]}}, dsum};
    x_u      = {{(U_W-X_W){1'b0}}, x_cur};
    p_upd    = dsum_u * x_u;
    upd      = p_upd >>> (X_W + LR_SHIFT);
    g_diff   = $signed({{(U_W+2-W_W){1'b0}}, g_cur}) - $signed({{2{upd[U_W-1]}}, upd});
    if (g_diff[U_W+1])           g_new = '0;
    else if (|g_diff[U_W:W_W])   g_new = '1;
    else                         g_new = g_diff[W_W-1:0];
  end

  always_comb begin
    state_d     = state_q;
    g_d         = g_q;
    x_d         = x_q;
    d1_d        = d1_q;
    d2_d        = d2_q;
    sel_d       = sel_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    acc_out_d   = acc_out_q;
    dlt_out_d   = dlt_out_q;
    dlt_idx_d   = dlt_idx_q;
    acc_valid_d = 1'b0;
    dlt_valid_d = 1'b0;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          sel_d = cmd_sel;
          cnt_d = cmd_arg;
          x_d   = x_in;
          d1_d  = d_in1;
          d2_d  = d_in2;
          idx_d = '0;
          acc_d = '0;
          case (cmd)
            CMD_CLR: begin
              g_d    = '0;
              done_d = 1'b1;
            end
            CMD_SET: begin
              if (cmd_arg == 8'd0) done_d  = 1'b1;
              else                 state_d = S_SET;
            end
            CMD_FWD: state_d = S_FWD;
            CMD_BCK: state_d = S_BACK;
            default: state_d = S_IDLE;
          endcase
        end
      end
      S_SET: begin
        if (sel_ok) g_d[sel_q] = set_val;
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      S_FWD: begin
        if (last) begin
          acc_out_d   = acc_sum;
          acc_valid_d = 1'b1;
          done_d      = 1'b1;
          state_d     = S_IDLE;
        end else begin
          acc_d = acc_sum;
          idx_d = idx_q + 1'b1;
        end
      end
      S_BACK: begin
        g_d[idx_q]  = g_new;
        dlt_out_d   = dlt_val;
        dlt_idx_d   = idx_q;
        dlt_valid_d = 1'b1;
        if (last) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Word line low wins over everything, including a final-cycle strobe.
    if (!wl) begin
      state_d     = S_IDLE;
      g_d         = '0;
      acc_out_d   = '0;
      dlt_out_d   = '0;
      dlt_idx_d   = '0;
      acc_valid_d = 1'b0;
      dlt_valid_d = 1'b0;
      done_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      g_q         <= '0;
      x_q         <= '0;
      d1_q        <= '0;
      d2_q        <= '0;
      sel_q       <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      acc_out_q   <= '0;
      dlt_out_q   <= '0;
      dlt_idx_q   <= '0;
      acc_valid_q <= 1'b0;
      dlt_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      g_q         <= g_d;
      x_q         <= x_d;
      d1_q        <= d1_d;
      d2_q        <= d2_d;
      sel_q       <= sel_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      acc_out_q   <= acc_out_d;
      dlt_out_q   <= dlt_out_d;
      dlt_idx_q   <= dlt_idx_d;
      acc_valid_q <= acc_valid_d;
      dlt_valid_q <= dlt_valid_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_rram_synapse_row.sv
// Randomized bench for rram_synapse_row: a transaction-level model predicts every strobe
// and value per cycle; a negedge process compares the DUT against it.
module tb_rram_synapse_row;
  localparam int N = 4, WW = 8, XW = 8, DW = 8, LRS = 3, STEP = 1;
  localparam int SW = 2, AW = 18, OW = 17, MAXC = 20000;

  logic clk = 1'b0, rst = 1'b1, wl = 1'b1;
  logic [1:0] cmd = '0;
  logic [7:0] cmd_arg = '0;
  logic [SW-1:0] cmd_sel = '0;
  logic cmd_valid = 1'b0, cmd_ready;
  logic [N*XW-1:0] x_in = '0;
  logic [DW-1:0] d_in1 = '0, d_in2 = '0;
  logic [AW-1:0] acc_out;
  logic acc_valid, dlt_valid, done;
  logic [OW-1:0] dlt_out;
  logic [SW-1:0] dlt_idx;
  logic [WW-1:0] g_out;

  rram_synapse_row dut (
    .clk(clk), .rst(rst), .wl(wl), .cmd(cmd), .cmd_arg(cmd_arg), .cmd_sel(cmd_sel),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .x_in(x_in), .d_in1(d_in1), .d_in2(d_in2),
    .acc_out(acc_out), .acc_valid(acc_valid), .dlt_out(dlt_out), .dlt_idx(dlt_idx),
    .dlt_valid(dlt_valid), .done(done), .g_out(g_out)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;
  bit chk_en = 1'b0;

  // Model: conductances plus per-cycle expectations (cycle k = interval after posedge k).
  int gm[N];
  bit e_done[MAXC], e_av[MAXC], e_dv[MAXC], e_busy[MAXC], e_aset[MAXC];
  int e_di[MAXC], e_dl[MAXC], e_acc[MAXC];
  int cur_acc = 0, last_acc = 0;
  int cap_dlt[N];
  int ck;

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    ck = cyc;
    if (ck < MAXC) begin
      if (e_aset[ck]) cur_acc = e_acc[ck];
      if (chk_en && !rst) begin
        check("done", done, e_done[ck]);
        check("acc_valid", acc_valid, e_av[ck]);
        check("dlt_valid", dlt_valid, e_dv[ck]);
        if (e_dv[ck]) begin
          check("dlt_idx", dlt_idx, e_di[ck]);
          check("dlt_out", $signed(dlt_out), e_dl[ck]);
        end
        check("acc_out", acc_out, cur_acc);
        check("cmd_ready", cmd_ready, wl && !e_busy[ck]);
        if (dlt_valid) cap_dlt[dlt_idx] = int'($signed(dlt_out));
        if (acc_valid) last_acc = int'(acc_out);
      end
    end
  end

  task automatic nedge();
    @(negedge clk);
    #2;
  endtask

  task automatic sweep();
    for (int i = 0; i < N; i++) begin
      cmd_sel = SW'(i);
      #1;
      check("g_out", g_out, gm[i]);
    end
  endtask

  task automatic drive(input logic [1:0] c, input int arg, input int sel,
                       input logic [N*XW-1:0] xp, input logic signed [DW-1:0] d1,
                       input logic signed [DW-1:0] d2, output int e);
    int t, sum, ds, x, xq, dl, upd, ng;
    t = cyc + 1;
    cmd = c; cmd_arg = 8'(arg); cmd_sel = SW'(sel); x_in = xp;
    d_in1 = d1; d_in2 = d2; cmd_valid = 1'b1;
    e = t;
    case (c)
      2'd0: for (int i = 0; i < N; i++) gm[i] = 0;
      2'd1: if (arg != 0) begin
        gm[sel] = (gm[sel] + arg * STEP > 255) ? 255 : gm[sel] + arg * STEP;
        e = t + arg;
      end
      2'd2: begin
        sum = 0;
        for (int i = 0; i < N; i++) sum += gm[i] * int'(xp[i*XW +: XW]);
        e = t + N;
        e_av[e] = 1'b1; e_aset[e] = 1'b1; e_acc[e] = sum;
      end
      default: begin
        ds = int'(d1) + int'(d2);
        for (int i = 0; i < N; i++) begin
          x   = int'(xp[i*XW +: XW]);
          xq  = (x * (256 - x)) / 256;
          dl  = (ds * gm[i] * xq) >>> XW;
          upd = (ds * x) >>> (XW + LRS);
          ng  = gm[i] - upd;
          ng  = (ng < 0) ? 0 : (ng > 255) ? 255 : ng;
          e_dv[t+1+i] = 1'b1; e_di[t+1+i] = i; e_dl[t+1+i] = dl;
          gm[i] = ng;
        end
        e = t + N;
      end
    endcase
    e_done[e] = 1'b1;
    for (int k = t; k < e; k++) e_busy[k] = 1'b1;
    nedge();
    // Scramble operands after acceptance: the op must use its latched copies.
    cmd_valid = 1'b0;
    x_in = $urandom; d_in1 = DW'($urandom); d_in2 = DW'($urandom); cmd_arg = 8'($urandom);
  endtask

  task automatic finish_cmd(input int e);
    while (cyc < e) nedge();
    check("done_at_end", done, 1);
    sweep();
  endtask

  task automatic run(input logic [1:0] c, input int arg, input int sel,
                     input logic [N*XW-1:0] xp, input logic signed [DW-1:0] d1,
                     input logic signed [DW-1:0] d2);
    int e;
    drive(c, arg, sel, xp, d1, d2, e);
    finish_cmd(e);
  endtask

  task automatic kill_exp(input int from);
    for (int k = from; k < from + 300 && k < MAXC; k++) begin
      e_done[k] = 0; e_av[k] = 0; e_dv[k] = 0; e_busy[k] = 0; e_aset[k] = 0;
    end
    e_aset[from] = 1'b1; e_acc[from] = 0;
    for (int i = 0; i < N; i++) gm[i] = 0;
  endtask

  task automatic read_g(input int sel, input string name, input int exp);
    cmd_sel = SW'(sel);
    #1;
    check(name, g_out, exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  int e, r, arg;
  logic signed [DW-1:0] rd1, rd2;
  logic [1:0] rc;

  initial begin
    for (int i = 0; i < N; i++) begin gm[i] = 0; cap_dlt[i] = 0; end
    // Reset state
    repeat (3) nedge();
    check("rst_acc_out", acc_out, 0);
    check("rst_dlt_out", dlt_out, 0);
    check("rst_dlt_idx", dlt_idx, 0);
    check("rst_strobes", {acc_valid, dlt_valid, done}, 0);
    check("rst_cmd_ready", cmd_ready, 0);
    for (int i = 0; i < N; i++) read_g(i, "rst_g", 0);
    rst = 1'b0;
    nedge();
    check("ready_after_rst", cmd_ready, 1);
    chk_en = 1'b1;

    // SET timing and saturation
    run(2'd1, 10, 2, '0, 0, 0);
    read_g(2, "set10", 10);
    run(2'd1, 255, 2, '0, 0, 0);
    run(2'd1, 255, 2, '0, 0, 0);
    read_g(2, "set_sat", 255);
    run(2'd1, 0, 2, '0, 0, 0);
    read_g(2, "set_len0", 255);

    // FWD known vector
    run(2'd0, 0, 0, '0, 0, 0);
    run(2'd1, 10, 0, '0, 0, 0);
    run(2'd1, 20, 1, '0, 0, 0);
    run(2'd1, 255, 3, '0, 0, 0);
    run(2'd2, 0, 0, {8'd255, 8'd255, 8'd64, 8'd128}, 0, 0);
    check("fwd_literal", last_acc, 67585);
    check("fwd_hold", acc_out, 67585);

    // BACK positive / negative delta, then clamp at zero
    run(2'd0, 0, 0, '0, 0, 0);
    run(2'd1, 100, 0, '0, 0, 0);
    run(2'd3, 0, 0, {8'd0, 8'd0, 8'd0, 8'd128}, 8'sd40, 8'sd24);
    check("back_pos_dlt", cap_dlt[0], 1600);
    read_g(0, "back_pos_g", 96);
    run(2'd0, 0, 0, '0, 0, 0);
    run(2'd1, 100, 0, '0, 0, 0);
    run(2'd3, 0, 0, {8'd0, 8'd0, 8'd0, 8'd128}, -8'sd40, -8'sd24);
    check("back_neg_dlt", cap_dlt[0], -1600);
    read_g(0, "back_neg_g", 104);
    run(2'd0, 0, 0, '0, 0, 0);
    run(2'd1, 2, 1, '0, 0, 0);
    run(2'd3, 0, 0, {8'd0, 8'd0, 8'd255, 8'd0}, 8'sd127, 8'sd0);
    read_g(1, "back_clamp", 0);

    // wl drop mid-FWD
    run(2'd1, 50, 3, '0, 0, 0);
    drive(2'd2, 0, 0, 32'hFFFF_FFFF, 0, 0, e);
    nedge();
    wl = 1'b0;
    kill_exp(cyc + 1);
    nedge();
    check("wl_dlt_clear", dlt_out, 0);
    repeat (2) nedge();
    check("wl_ready_low", cmd_ready, 0);
    wl = 1'b1;
    nedge();
    sweep();

    // wl drop coincident with the final BACK edge
    run(2'd1, 80, 1, '0, 0, 0);
    drive(2'd3, 0, 0, 32'h8080_8080, 8'sd50, 8'sd10, e);
    while (cyc < e - 1) nedge();
    wl = 1'b0;
    kill_exp(cyc + 1);
    nedge();
    wl = 1'b1;
    nedge();
    sweep();

    // rst mid-SET
    drive(2'd1, 20, 0, '0, 0, 0, e);
    repeat (3) nedge();
    rst = 1'b1;
    kill_exp(cyc + 1);
    #1;
    check("rst_mid_done", done, 0);
    check("rst_mid_ready", cmd_ready, 0);
    sweep();
    repeat (2) nedge();
    rst = 1'b0;
    nedge();
    sweep();

    // Randomized back-to-back traffic
    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 9);
      rc = (r == 0) ? 2'd0 : (r < 4) ? 2'd1 : (r < 7) ? 2'd2 : 2'd3;
      arg = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 12);
      rd1 = DW'($urandom);
      rd2 = DW'($urandom);
      run(rc, arg, $urandom_range(0, N - 1), $urandom, rd1, rd2);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) nedge();
    end

    repeat (2) nedge();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rram_synapse_row.md
# rram_synapse_row

Clocked, parametrised digital model of a row of `N_CELL` RRAM synapses with a shared word line. It holds one unsigned conductance per cell and supports pulse-width SET programming, a serial forward multiply-accumulate and a serial backward pass. The backward pass emits per-cell error deltas and applies a shifted-learning-rate update to each conductance. It sits between the layer sequencer and the array column drivers and replaces per-cell analog behaviour with a cycle-accurate, synthesizable equivalent.

## Interface
- `N_CELL`, 4: number of cells in the row.
- `W_W`, 8: conductance width, unsigned, range 0..2^W_W-1.
- `X_W`, 8: activation width, unsigned Q0.X_W.
- `D_W`, 8: width of each incoming delta, signed.
- `LR_SHIFT`, 3: learning rate is 2^-LR_SHIFT.
- `SET_STEP`, 1: conductance increment per SET cycle.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `wl` input 1: word line; low forces the row into the reset condition.
- `cmd` input 2: command; 0 CLR, 1 SET, 2 FWD, 3 BACK.
- `cmd_arg` input 8: SET pulse length in cycles.
- `cmd_sel` input clog2(N_CELL): SET target cell.
- `cmd_valid` input 1: command request.
- `cmd_ready` output 1: high when `state==IDLE && wl && !rst`.
- `x_in` input N_CELL*X_W: activations; cell i occupies bits [i*X_W +: X_W].
- `d_in1`, `d_in2` input D_W each: signed deltas from the two downstream paths.
- `acc_out` output W_W+X_W+clog2(N_CELL): forward sum.
- `acc_valid` output 1: one-cycle strobe for `acc_out`.
- `dlt_out` output D_W+1+W_W: signed per-cell delta.
- `dlt_idx` output clog2(N_CELL): index of the cell that produced `dlt_out`.
- `dlt_valid` output 1: one-cycle strobe per cell.
- `done` output 1: one-cycle strobe when a command completes.
- `g_out` output W_W: combinational readback of G[`cmd_sel`].

## Operation
- FSM states are IDLE, SET, FWD, BACK. A command is accepted on an edge where `cmd_valid && cmd_ready`. `x_in`, `d_in1`, `d_in2`, `cmd_sel` and `cmd_arg` are latched at acceptance; later changes have no effect on an op in flight.
- CLR: all G cleared at the acceptance edge; `done` is high the following cycle; the FSM stays in IDLE.
- SET: the FSM enters SET with a counter loaded from `cmd_arg`. Each SET cycle updates G[sel] = min(G+SET_STEP, 2^W_W-1) and decrements the counter. When the counter reaches 0 the FSM returns to IDLE and pulses `done`. `cmd_arg`=0 returns to IDLE with `done` and leaves G unchanged.
- FWD: one cell per cycle, i=0..N_CELL-1, acc += G[i]*x[i], full precision with no truncation. After the last cell, `acc_out` holds the sum and `acc_valid` and `done` pulse together. `acc_out` then holds its value until the next FWD result, reset, or `wl` low.
- BACK: one cell per cycle, i ascending.
  - dsum = d_in1 + d_in2, signed, D_W+1 bits.
  - xq = (x*(2^X_W - x)) >> X_W.
  - `dlt_out` = (dsum*G_old*xq) >>> X_W, computed from G before the update; `dlt_valid` pulses with `dlt_idx`=i.
  - upd = (dsum*x) >>> (X_W+LR_SHIFT), arithmetic shift, floor.
  - G[i] = clamp(G_old - upd, 0, 2^W_W-1).
  - `done` pulses in the cycle of the last `dlt_valid`.
- `wl` low, sampled at an edge: all G cleared, FSM forced to IDLE, any op aborted with no `done` or valid strobes, `acc_out` and `dlt_out` cleared. While `wl` stays low, `cmd_ready` is 0.

## Timing
- Reset (async assert, sync release) sets:
  - every G to 0 and the state to IDLE;
  - `acc_out`, `dlt_out`, `dlt_idx` to 0;
  - `acc_valid`, `dlt_valid`, `done` to 0;
  - `cmd_ready` to 0 while `rst` is high.
- Latency, with acceptance at edge T:
  - CLR: `done` at T+1.
  - SET with length L>0: G increments at edges T+1..T+L, `done` is high in the cycle after edge T+L.
  - FWD: `acc_valid` is high in the cycle after edge T+N_CELL.
  - BACK: cell i's `dlt_valid` is high in the cycle after edge T+1+i.
- `cmd_ready` is low from acceptance until the cycle `done` is high. A new command may be accepted in the `done` cycle, which gives back-to-back throughput.
- `wl` falling coincident with the final op edge takes precedence: no strobe, G cleared.
- Reset asserted mid-op aborts immediately with no strobes.

## Test plan
Bench parameters are the defaults.

- Reset: assert `rst` with `wl`=1 -> all outputs 0, `g_out`=0 for every `cmd_sel`. After release, `cmd_ready`=1.
- SET: SET sel=2 len=10 -> G[2]=10 and `done` exactly 11 cycles after acceptance. Two SETs of 255 -> G[2]=255, saturated. SET len=0 -> `done` at T+1, G unchanged.
- FWD: G=[10,20,0,255], x=[128,64,255,255] -> `acc_out`=67585 with `acc_valid` in the cycle after edge T+4, single pulse.
- BACK, positive and negative delta:
  - G0=100, x0=128, d1=40, d2=24 -> `dlt_out`[0]=1600, G0=96.
  - d1=-40, d2=-24 -> `dlt_out`[0]=-1600, G0=104.
- BACK clamp: G1=2, x1=255, d1=127, d2=0 -> upd=15, G1=0, no wrap.
- Aborts:
  - Drop `wl` during FWD at cycle 2 -> no `acc_valid`, no `done`, all G=0, `cmd_ready`=0 until `wl`=1.
  - Assert `rst` mid-SET -> G=0 and state IDLE immediately, no `done`.
